// File: rtl/dma_mem_responder_pkg.sv
// Shared definitions for the DMA memory responder: default geometry and FSM state encoding.
// Core-control benches import this to decode the responder state.
package dma_mem_responder_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultAddrW = 6;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StProcc  = 3'd2,
    StRdwait = 3'd3,
    StDone   = 3'd4,
    StErr    = 3'd5
  } dma_state_e;

endpackage

// File: rtl/dma_mem_array.sv
// Synchronous single-port word RAM with a registered read port.
// Contents and the read register are not reset.
module dma_mem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  // The read register only updates on a read, so data stays put while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dma_mem_responder.sv
// DMA memory responder: accepts a write burst, hands the loaded words to the processing unit
// one read at a time, and signals completion once every loaded word has been consumed.
module dma_mem_responder
  import dma_mem_responder_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              mc_clk,
  input  logic              mc_reset,
  input  logic              mc_req,
  input  logic              mc_we,
  input  logic [ADDR_W-1:0] mc_data_address_in,
  input  logic [DATA_W-1:0] mc_wdata,
  input  logic              mc_last,
  input  logic              procc_ready,
  input  logic              mc_err_clr,
  output logic [DATA_W-1:0] mc_rdata,
  output logic              mc_rvalid,
  output logic              mc_cont_procc,
  output logic              mc_data_done,
  output logic              mc_err,
  output logic              mc_busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CntOne = {{ADDR_W{1'b0}}, 1'b1};

  dma_state_e        state_q, state_d;
  logic [Depth-1:0]  valid_q, valid_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] ram_rdata;

  logic in_fill;
  logic in_procc;
  logic addr_valid;
  logic wr_ok;
  logic rd_ok;
  logic req_err;

  assign in_fill    = (state_q == StIdle) || (state_q == StLoad);
  assign in_procc   = (state_q == StProcc);
  assign addr_valid = valid_q[mc_data_address_in];

  // Requests in busy states fall through all three terms and are silently dropped.
  assign wr_ok   = in_fill & mc_req & mc_we;
  assign rd_ok   = in_procc & mc_req & ~mc_we & addr_valid;
  assign req_err = mc_req & ((in_fill & ~mc_we) | (in_procc & (mc_we | ~addr_valid)));

  dma_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (mc_clk),
    .we_i    (wr_ok),
    .re_i    (rd_ok),
    .addr_i  (mc_data_address_in),
    .wdata_i (mc_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge mc_clk or negedge mc_reset) begin
    if (!mc_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StLoad: begin
        if (wr_ok) begin
          state_d = mc_last ? StProcc : StLoad;
        end else if (req_err) begin
          state_d = StErr;
        end
      end
      StProcc: begin
        if (rd_ok) begin
          state_d = StRdwait;
        end else if (req_err) begin
          state_d = StErr;
        end
      end
      StRdwait: begin
        // count_q already reflects the word being handed over.
        if (procc_ready) begin
          state_d = (count_q == '0) ? StDone : StProcc;
        end
      end
      StDone: state_d = StIdle;
      StErr: begin
        if (mc_err_clr) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mc_rvalid     = 1'b0;
    mc_cont_procc = 1'b0;
    mc_data_done  = 1'b0;
    mc_err        = 1'b0;
    mc_busy       = 1'b0;
    unique case (state_q)
      StProcc: mc_cont_procc = 1'b1;
      StRdwait: begin
        mc_rvalid     = 1'b1;
        mc_cont_procc = 1'b1;
        mc_busy       = 1'b1;
      end
      StDone: begin
        mc_data_done = 1'b1;
        mc_busy      = 1'b1;
      end
      StErr: begin
        mc_err  = 1'b1;
        mc_busy = 1'b1;
      end
      default: ;
    endcase
    mc_rdata = mc_rvalid ? ram_rdata : '0;
  end

  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    if (wr_ok) begin
      valid_d[mc_data_address_in] = 1'b1;
      if (!addr_valid) begin
        count_d = count_q + CntOne;
      end
    end else if (rd_ok) begin
      valid_d[mc_data_address_in] = 1'b0;
      count_d = count_q - CntOne;
    end else if ((state_q == StErr) && mc_err_clr) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge mc_clk or negedge mc_reset) begin
    if (!mc_reset) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed self-checking bench for dma_mem_responder.
module tb_dma_mem_responder;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;

  logic          mc_clk;
  logic          mc_reset;
  logic          mc_req;
  logic          mc_we;
  logic [AW-1:0] mc_data_address_in;
  logic [DW-1:0] mc_wdata;
  logic          mc_last;
  logic          procc_ready;
  logic          mc_err_clr;
  logic [DW-1:0] mc_rdata;
  logic          mc_rvalid;
  logic          mc_cont_procc;
  logic          mc_data_done;
  logic          mc_err;
  logic          mc_busy;

  int n_pass  = 0;
  int n_total = 0;

  dma_mem_responder #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .mc_clk             (mc_clk),
    .mc_reset           (mc_reset),
    .mc_req             (mc_req),
    .mc_we              (mc_we),
    .mc_data_address_in (mc_data_address_in),
    .mc_wdata           (mc_wdata),
    .mc_last            (mc_last),
    .procc_ready        (procc_ready),
    .mc_err_clr         (mc_err_clr),
    .mc_rdata           (mc_rdata),
    .mc_rvalid          (mc_rvalid),
    .mc_cont_procc      (mc_cont_procc),
    .mc_data_done       (mc_data_done),
    .mc_err             (mc_err),
    .mc_busy            (mc_busy)
  );

  initial mc_clk = 1'b0;
  always #5 mc_clk = ~mc_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge mc_clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic last);
    mc_req = 1'b1;
    mc_we = 1'b1;
    mc_data_address_in = a;
    mc_wdata = d;
    mc_last = last;
    step();
    mc_req = 1'b0;
    mc_we = 1'b0;
    mc_last = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    mc_req = 1'b1;
    mc_we = 1'b0;
    mc_data_address_in = a;
    step();
    mc_req = 1'b0;
  endtask

  task automatic ack();
    procc_ready = 1'b1;
    step();
    procc_ready = 1'b0;
  endtask

  task automatic clr();
    mc_err_clr = 1'b1;
    step();
    mc_err_clr = 1'b0;
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    pat = (i * 32'h0101_0101) ^ 32'h5A00_005A;
  endfunction

  initial begin
    mc_reset = 1'b0;
    mc_req = 1'b0;
    mc_we = 1'b0;
    mc_data_address_in = '0;
    mc_wdata = '0;
    mc_last = 1'b0;
    procc_ready = 1'b0;
    mc_err_clr = 1'b0;
    #1;
    chk("rst_rvalid", 64'(mc_rvalid), 64'd0);
    chk("rst_cont", 64'(mc_cont_procc), 64'd0);
    chk("rst_done", 64'(mc_data_done), 64'd0);
    chk("rst_err", 64'(mc_err), 64'd0);
    chk("rst_busy", 64'(mc_busy), 64'd0);
    chk("rst_rdata", 64'(mc_rdata), 64'd0);
    step();
    step();
    mc_reset = 1'b1;
    step();

    // Two-word burst, then read both back.
    wr(6'd3, 32'hA5A5_0001, 1'b0);
    chk("load_cont", 64'(mc_cont_procc), 64'd0);
    chk("load_busy", 64'(mc_busy), 64'd0);
    wr(6'd7, 32'h0000_0002, 1'b1);
    chk("burst_cont", 64'(mc_cont_procc), 64'd1);
    chk("burst_count", 64'(dut.count_q), 64'd2);
    rd(6'd3);
    chk("rd3_rvalid", 64'(mc_rvalid), 64'd1);
    chk("rd3_rdata", 64'(mc_rdata), 64'hA5A5_0001);
    chk("rd3_busy", 64'(mc_busy), 64'd1);
    ack();
    chk("ack3_rvalid", 64'(mc_rvalid), 64'd0);
    chk("ack3_done", 64'(mc_data_done), 64'd0);
    chk("ack3_cont", 64'(mc_cont_procc), 64'd1);
    rd(6'd7);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rvalid", 64'(mc_rvalid), 64'd1);
      chk("hold_rdata", 64'(mc_rdata), 64'h0000_0002);
      chk("hold_busy", 64'(mc_busy), 64'd1);
      // A write while busy must be dropped without error.
      if (i == 2) begin
        wr(6'd10, 32'hFFFF_FFFF, 1'b1);
      end else begin
        step();
      end
    end
    chk("busy_req_err", 64'(mc_err), 64'd0);
    chk("busy_req_count", 64'(dut.count_q), 64'd0);
    ack();
    chk("done_pulse", 64'(mc_data_done), 64'd1);
    chk("done_cont", 64'(mc_cont_procc), 64'd0);
    chk("done_rvalid", 64'(mc_rvalid), 64'd0);
    step();
    chk("done_once", 64'(mc_data_done), 64'd0);
    chk("idle_busy", 64'(mc_busy), 64'd0);

    // Overwrite keeps count at one.
    wr(6'd5, 32'h0000_0011, 1'b0);
    wr(6'd5, 32'h0000_0022, 1'b1);
    chk("ovw_count", 64'(dut.count_q), 64'd1);
    chk("ovw_err", 64'(mc_err), 64'd0);
    rd(6'd5);
    chk("ovw_rdata", 64'(mc_rdata), 64'h0000_0022);
    ack();
    chk("ovw_done", 64'(mc_data_done), 64'd1);
    step();

    // Error paths.
    wr(6'd3, 32'hCAFE_0003, 1'b1);
    clr();
    chk("clr_noeff_cont", 64'(mc_cont_procc), 64'd1);
    chk("clr_noeff_count", 64'(dut.count_q), 64'd1);
    rd(6'd9);
    chk("inv_err", 64'(mc_err), 64'd1);
    chk("inv_cont", 64'(mc_cont_procc), 64'd0);
    chk("inv_busy", 64'(mc_busy), 64'd1);
    chk("inv_count", 64'(dut.count_q), 64'd1);
    step();
    step();
    step();
    chk("err_sticky", 64'(mc_err), 64'd1);
    clr();
    chk("errclr_err", 64'(mc_err), 64'd0);
    chk("errclr_busy", 64'(mc_busy), 64'd0);
    chk("errclr_count", 64'(dut.count_q), 64'd0);
    rd(6'd3);
    chk("idle_rd_err", 64'(mc_err), 64'd1);
    clr();
    wr(6'd2, 32'h0000_0BAD, 1'b1);
    wr(6'd4, 32'h0000_0444, 1'b0);
    chk("procc_wr_err", 64'(mc_err), 64'd1);
    chk("procc_wr_count", 64'(dut.count_q), 64'd1);
    clr();

    // Reset while a read is pending.
    wr(6'd0, 32'hDEAD_BEEF, 1'b1);
    rd(6'd0);
    chk("pre_rst_rvalid", 64'(mc_rvalid), 64'd1);
    #2;
    mc_reset = 1'b0;
    #1;
    chk("midrst_rvalid", 64'(mc_rvalid), 64'd0);
    chk("midrst_cont", 64'(mc_cont_procc), 64'd0);
    chk("midrst_busy", 64'(mc_busy), 64'd0);
    chk("midrst_rdata", 64'(mc_rdata), 64'd0);
    chk("midrst_count", 64'(dut.count_q), 64'd0);
    step();
    mc_reset = 1'b1;
    step();
    wr(6'd0, 32'h0000_1234, 1'b1);
    rd(6'd0);
    chk("postrst_rdata", 64'(mc_rdata), 64'h0000_1234);
    ack();
    chk("postrst_done", 64'(mc_data_done), 64'd1);
    step();

    // Fill every address, then drain.
    for (int i = 0; i < 64; i++) begin
      wr(AW'(i), pat(i), (i == 63) ? 1'b1 : 1'b0);
    end
    chk("full_count", 64'(dut.count_q), 64'd64);
    chk("full_cont", 64'(mc_cont_procc), 64'd1);
    for (int i = 0; i < 64; i++) begin
      rd(AW'(i));
      chk("drain_rdata", 64'(mc_rdata), 64'(pat(i)));
      ack();
      chk("drain_done", 64'(mc_data_done), (i == 63) ? 64'd1 : 64'd0);
    end
    step();
    chk("drain_idle", 64'(mc_data_done), 64'd0);
    chk("drain_count", 64'(dut.count_q), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
